// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit: op encodings,
// per-stage level count, and the bit-reverse used around the left-shift core.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_t;

    localparam int MAX_XLEN = 64;

    // Number of shamt bits (mux levels) each register stage resolves.
    function automatic int levels_per_stage(input int shw, input int stages);
        return (shw + stages - 1) / stages;
    endfunction

    // Mirrors the low n bits of x; bits above n come back as zero.
    function automatic logic [MAX_XLEN-1:0] bit_reverse(input logic [MAX_XLEN-1:0] x, input int n);
        logic [MAX_XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = x[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of the shift pipe: applies shamt bits [LO .. LO+L-1]
// as left-shift mux levels, then registers value, fill, op, tag and shamt.
module shift_stage
    import shift_pkg::*;
#(
    parameter int VW    = 32,
    parameter int SHW   = 5,
    parameter int TAG_W = 5,
    parameter int LO    = 0,
    parameter int L     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_valid,
    input  logic             i_down_adv,
    output logic             o_adv,
    input  logic [VW-1:0]    i_value,
    input  logic             i_fill,
    input  shift_op_t        i_op,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_valid,
    output logic [VW-1:0]    o_value,
    output logic             o_fill,
    output shift_op_t        o_op,
    output logic [TAG_W-1:0] o_tag,
    output logic [SHW-1:0]   o_shamt
);

    // Pad so the last stage may own fewer than L real shamt bits.
    localparam int PW = (LO + L > SHW) ? LO + L : SHW;

    logic             r_valid;
    logic [VW-1:0]    r_value;
    logic             r_fill;
    shift_op_t        r_op;
    logic [TAG_W-1:0] r_tag;
    logic [SHW-1:0]   r_shamt;

    logic [PW-1:0]    w_sh_pad;
    logic [VW-1:0]    w_shifted;
    logic             w_adv;
    logic             w_unused;

    assign w_sh_pad = PW'(i_shamt);
    assign w_unused = ^w_sh_pad;

    always_comb begin
        w_shifted = i_value;
        for (int j = 0; j < L; j++) begin
            if (w_sh_pad[LO+j]) begin
                w_shifted = (w_shifted << (1 << (LO + j)))
                          | (~({VW{1'b1}} << (1 << (LO + j))) & {VW{i_fill}});
            end
        end
    end

    assign w_adv = !r_valid || i_down_adv;
    assign o_adv = w_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_value <= '0;
            r_fill  <= 1'b0;
            r_op    <= OP_SLL;
            r_tag   <= '0;
            r_shamt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid <= i_valid;
            end
            if (w_adv && i_valid) begin
                r_value <= w_shifted;
                r_fill  <= i_fill;
                r_op    <= i_op;
                r_tag   <= i_tag;
                r_shamt <= i_shamt;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_value = r_value;
    assign o_fill  = r_fill;
    assign o_op    = r_op;
    assign o_tag   = r_tag;
    assign o_shamt = r_shamt;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA shifter with tag passthrough, backpressure and flush.
// Define SHIFT_ROTATE_EN to decode ROL/ROR on a doubled-width {x, x} core.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    localparam int SHW   = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  shift_op_t        in_op,
    input  logic [XLEN-1:0]  in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // ready never depends on valid of the same side; flush overrides acceptance.
`ifdef SHIFT_ROTATE_EN
    localparam int VW = 2 * XLEN;
`else
    localparam int VW = XLEN;
`endif
    localparam int L = levels_per_stage(SHW, STAGES);

    logic [MAX_XLEN-1:0] w_in_rev_full;
    logic [MAX_XLEN-1:0] w_out_rev_full;
    logic [XLEN-1:0]     w_in_rev;
    logic [XLEN-1:0]     w_out_rev;
    logic [XLEN-1:0]     w_hi;
    logic [XLEN-1:0]     w_lo;
    logic [XLEN-1:0]     w_upper;

    logic [VW-1:0]       w_val   [0:STAGES];
    shift_op_t           w_op    [0:STAGES];
    logic [TAG_W-1:0]    w_tag   [0:STAGES];
    logic [SHW-1:0]      w_shamt [0:STAGES];
    logic [STAGES:0]     w_valid;
    logic [STAGES:0]     w_fill;
    logic [STAGES-1:0]   w_adv;
    logic [STAGES-1:0]   w_down;
    logic                w_unused;

    assign w_in_rev_full = bit_reverse(MAX_XLEN'(in_data), XLEN);
    assign w_in_rev      = w_in_rev_full[XLEN-1:0];

    // Right shifts run through the left-shift core on the mirrored operand;
    // w_lo is what slides into the upper half (fill, sign copy or rotate wrap).
    always_comb begin
        w_hi       = in_data;
        w_lo       = '0;
        w_fill[0]  = 1'b0;
        w_shamt[0] = in_shamt;
        case (in_op)
            OP_SLL: ;
            OP_SRL: w_hi = w_in_rev;
            OP_SRA: begin
                w_hi      = w_in_rev;
                w_lo      = {XLEN{in_data[XLEN-1]}};
                w_fill[0] = in_data[XLEN-1];
            end
`ifdef SHIFT_ROTATE_EN
            OP_ROL: w_lo = in_data;
            OP_ROR: begin
                w_hi = w_in_rev;
                w_lo = w_in_rev;
            end
`endif
            default: w_shamt[0] = '0;
        endcase
    end

`ifdef SHIFT_ROTATE_EN
    assign w_val[0] = {w_hi, w_lo};
`else
    assign w_val[0] = w_hi;
`endif
    assign w_valid[0] = in_valid;
    assign w_op[0]    = in_op;
    assign w_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == STAGES - 1) begin : g_last
            assign w_down[s] = out_ready;
        end else begin : g_mid
            assign w_down[s] = w_adv[s+1];
        end

        shift_stage #(
            .VW    (VW),
            .SHW   (SHW),
            .TAG_W (TAG_W),
            .LO    (s * L),
            .L     (L)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .i_valid    (w_valid[s]),
            .i_down_adv (w_down[s]),
            .o_adv      (w_adv[s]),
            .i_value    (w_val[s]),
            .i_fill     (w_fill[s]),
            .i_op       (w_op[s]),
            .i_tag      (w_tag[s]),
            .i_shamt    (w_shamt[s]),
            .o_valid    (w_valid[s+1]),
            .o_value    (w_val[s+1]),
            .o_fill     (w_fill[s+1]),
            .o_op       (w_op[s+1]),
            .o_tag      (w_tag[s+1]),
            .o_shamt    (w_shamt[s+1])
        );
    end

    assign in_ready = w_adv[0];

    assign w_upper        = w_val[STAGES][VW-1 -: XLEN];
    assign w_out_rev_full = bit_reverse(MAX_XLEN'(w_upper), XLEN);
    assign w_out_rev      = w_out_rev_full[XLEN-1:0];

    always_comb begin
        out_result = w_upper;
        case (w_op[STAGES])
            OP_SRL, OP_SRA: out_result = w_out_rev;
`ifdef SHIFT_ROTATE_EN
            OP_ROR: out_result = w_out_rev;
`endif
            default: ;
        endcase
    end

    assign out_valid = w_valid[STAGES];
    assign out_tag   = w_tag[STAGES];

    assign w_unused = ^{w_in_rev_full, w_out_rev_full, w_lo, w_val[STAGES],
                        w_fill[STAGES], w_shamt[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe (XLEN=32, STAGES=2).
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int SHW    = 5;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    shift_op_t        in_op;
    logic [XLEN-1:0]  in_data;
    logic [SHW-1:0]   in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int n_vec = 0;
    int n_err = 0;
    logic [XLEN+TAG_W-1:0] exp_q[$];

    shift_unit_pipe #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_shift(input logic [2:0] op, input logic [XLEN-1:0] x, input int n);
        logic signed [XLEN-1:0] sx;
        sx = x;
        case (op)
            3'd0: return x << n;
            3'd1: return x >> n;
            3'd2: return sx >>> n;
`ifdef SHIFT_ROTATE_EN
            3'd3: return (n == 0) ? x : ((x << n) | (x >> (XLEN - n)));
            3'd4: return (n == 0) ? x : ((x >> n) | (x << (XLEN - n)));
`endif
            default: return x;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_op    = OP_SLL;
        in_data  = '0;
        in_shamt = '0;
        in_tag   = '0;
    endtask

    // Sends one op into an empty pipe and waits (bounded) for its result.
    task automatic run_one(input logic [2:0] op, input logic [XLEN-1:0] d, input logic [SHW-1:0] sh,
                           input logic [TAG_W-1:0] tg, output logic [XLEN-1:0] res,
                           output logic [TAG_W-1:0] rt, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = shift_op_t'(op);
        in_data   = d;
        in_shamt  = sh;
        in_tag    = tg;
        out_ready = 1'b1;
        lat = 0;
        res = 'x;
        rt  = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                res = out_result;
                rt  = out_tag;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++;
        if (out_result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", out_result); end
        n_vec++;
        if (out_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_sll_latency();
        logic [XLEN-1:0] res;
        logic [TAG_W-1:0] rt;
        int lat;
        run_one(3'd0, 32'h0000_0001, 5'd31, 5'd7, res, rt, lat);
        n_vec++;
        if (lat != STAGES) begin n_err++; $display("FAIL sll_latency: got %0d want %0d", lat, STAGES); end
        n_vec++;
        if (res !== 32'h8000_0000) begin n_err++; $display("FAIL sll_result: got %h want 80000000", res); end
        n_vec++;
        if (rt !== 5'd7) begin n_err++; $display("FAIL sll_tag: got %0d want 7", rt); end
    endtask

    task automatic test_directed();
        logic [2:0]      v_op  [12];
        logic [XLEN-1:0] v_in  [12];
        logic [SHW-1:0]  v_sh  [12];
        logic [XLEN-1:0] v_exp [12];
        logic [XLEN-1:0] res;
        logic [TAG_W-1:0] rt;
        int lat;
        v_op[0]  = 3'd2; v_in[0]  = 32'h8000_0000; v_sh[0]  = 5'd4;  v_exp[0]  = 32'hF800_0000;
        v_op[1]  = 3'd1; v_in[1]  = 32'h8000_0000; v_sh[1]  = 5'd4;  v_exp[1]  = 32'h0800_0000;
        v_op[2]  = 3'd0; v_in[2]  = 32'hDEAD_BEEF; v_sh[2]  = 5'd0;  v_exp[2]  = 32'hDEAD_BEEF;
        v_op[3]  = 3'd1; v_in[3]  = 32'hDEAD_BEEF; v_sh[3]  = 5'd0;  v_exp[3]  = 32'hDEAD_BEEF;
        v_op[4]  = 3'd2; v_in[4]  = 32'h8000_0000; v_sh[4]  = 5'd0;  v_exp[4]  = 32'h8000_0000;
        v_op[5]  = 3'd2; v_in[5]  = 32'h7000_0000; v_sh[5]  = 5'd31; v_exp[5]  = 32'h0000_0000;
        v_op[6]  = 3'd2; v_in[6]  = 32'h8000_0001; v_sh[6]  = 5'd31; v_exp[6]  = 32'hFFFF_FFFF;
        v_op[7]  = 3'd1; v_in[7]  = 32'hFFFF_FFFF; v_sh[7]  = 5'd31; v_exp[7]  = 32'h0000_0001;
        v_op[8]  = 3'd0; v_in[8]  = 32'h0000_00FF; v_sh[8]  = 5'd8;  v_exp[8]  = 32'h0000_FF00;
        v_op[9]  = 3'd1; v_in[9]  = 32'h1234_5678; v_sh[9]  = 5'd16; v_exp[9]  = 32'h0000_1234;
        v_op[10] = 3'd5; v_in[10] = 32'hA5A5_A5A5; v_sh[10] = 5'd3;  v_exp[10] = 32'hA5A5_A5A5;
`ifdef SHIFT_ROTATE_EN
        v_op[11] = 3'd4; v_in[11] = 32'h0000_0001; v_sh[11] = 5'd1;  v_exp[11] = 32'h8000_0000;
`else
        v_op[11] = 3'd4; v_in[11] = 32'h1234_5678; v_sh[11] = 5'd5;  v_exp[11] = 32'h1234_5678;
`endif
        for (int i = 0; i < 12; i++) begin
            run_one(v_op[i], v_in[i], v_sh[i], TAG_W'(i + 16), res, rt, lat);
            n_vec++;
            if (res !== v_exp[i] || rt !== TAG_W'(i + 16)) begin
                n_err++;
                $display("FAIL directed_%0d: got %h tag %0d want %h tag %0d", i, res, rt, v_exp[i], i + 16);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        int gaps;
        logic [2:0] op;
        logic [XLEN-1:0] d;
        logic [SHW-1:0] sh;
        logic [XLEN+TAG_W-1:0] e;
        sent = 0;
        got  = 0;
        gaps = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 100 + STAGES + 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got %h tag %0d want no result", out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_tag} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result_%0d: got %h tag %0d want %h tag %0d",
                                 got, out_result, out_tag, e[XLEN+TAG_W-1:TAG_W], e[TAG_W-1:0]);
                    end
                end
                got++;
            end else if (got > 0 && got < 100) begin
                gaps++;
            end
            if (sent < 100) begin
                op = 3'($urandom_range(0, 7));
                d  = $urandom();
                sh = SHW'($urandom_range(0, XLEN - 1));
                in_valid = 1'b1;
                in_op    = shift_op_t'(op);
                in_data  = d;
                in_shamt = sh;
                in_tag   = TAG_W'(sent);
                #1;
                if (in_ready) begin
                    exp_q.push_back({ref_shift(op, d, int'(sh)), TAG_W'(sent)});
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 100) begin n_err++; $display("FAIL b2b_count: got %0d want 100", got); end
        n_vec++;
        if (gaps != 0) begin n_err++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] bp_exp [6];
        logic [XLEN-1:0] held_r;
        logic [TAG_W-1:0] held_t;
        logic [XLEN+TAG_W-1:0] e;
        int acc;
        int drained;
        int extra;
        bp_exp[0] = 32'h6;  bp_exp[1] = 32'hC;  bp_exp[2] = 32'h18;
        bp_exp[3] = 32'h30; bp_exp[4] = 32'h60; bp_exp[5] = 32'hC0;
        exp_q.delete();
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = OP_SLL;
            in_data  = 32'h0000_0003;
            in_shamt = SHW'(acc + 1);
            in_tag   = TAG_W'(20 + acc);
            #1;
            if (in_ready) begin
                exp_q.push_back({bp_exp[acc], TAG_W'(20 + acc)});
                acc++;
            end
        end
        n_vec++;
        if (acc != STAGES) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc, STAGES); end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== 32'h6 || out_tag !== 5'd20) begin
            n_err++;
            $display("FAIL bp_head: got v=%b %h tag %0d want v=1 00000006 tag 20", out_valid, out_result, out_tag);
        end
        held_r = out_result;
        held_t = out_tag;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (out_result !== held_r || out_tag !== held_t) begin
                n_err++;
                $display("FAIL bp_stable: got %h tag %0d want %h tag %0d", out_result, out_tag, held_r, held_t);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready); end
        drained = 0;
        extra   = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({out_result, out_tag} !== e) begin
                        n_err++;
                        $display("FAIL bp_drain_%0d: got %h tag %0d want %h tag %0d",
                                 drained, out_result, out_tag, e[XLEN+TAG_W-1:TAG_W], e[TAG_W-1:0]);
                    end
                end
                drained++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (drained != STAGES || extra != 0) begin
            n_err++;
            $display("FAIL bp_drain_count: got %0d (extra %0d) want %0d", drained, extra, STAGES);
        end
    endtask

    task automatic test_flush();
        int pulses;
        logic [XLEN-1:0] res;
        logic [TAG_W-1:0] rt;
        int lat;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SLL; in_data = 32'h1; in_shamt = 5'd1; in_tag = 5'd10;
        @(negedge clk);
        in_op = OP_SRL; in_data = 32'h80; in_shamt = 5'd2; in_tag = 5'd11;
        @(negedge clk);
        flush = 1'b1; in_op = OP_SRA; in_data = 32'h8000_0000; in_shamt = 5'd1; in_tag = 5'd12;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL flush_full_pulses: got %0d want 0", pulses); end

        // Empty pipe, so in_ready is high while flush is asserted.
        flush = 1'b1; in_valid = 1'b1; in_op = OP_SLL; in_data = 32'h5; in_shamt = 5'd1; in_tag = 5'd14;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty_ready: got %b want 1", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL flush_empty_pulses: got %0d want 0", pulses); end

        run_one(3'd1, 32'hF000_0000, 5'd28, 5'd13, res, rt, lat);
        n_vec++;
        if (res !== 32'h0000_000F || rt !== 5'd13 || lat != STAGES) begin
            n_err++;
            $display("FAIL flush_after: got %h tag %0d lat %0d want 0000000f tag 13 lat %0d", res, rt, lat, STAGES);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SLL; in_data = 32'h1; in_shamt = 5'd3; in_tag = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (out_result !== 32'h0 || out_tag !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid_regs: got %h tag %0d want 00000000 tag 0", out_result, out_tag);
        end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL reset_mid_pulses: got %0d want 0", pulses); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive_idle();
        test_reset();
        test_sll_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
